// File: rtl/forwarding_hazard_unit.sv
// ---------------------------------------------------------------------------
// forwarding_hazard_unit
//
// Keeps a scoreboard of register writes that are still in flight in the
// pipeline. From it, the unit picks a forwarding source for each of the two
// operands of the issuing instruction. It stalls issue when an operand depends
// on a load whose data is not yet available.
//
// Ports
//   clk_i            rising-edge clock
//   rst_n_i          asynchronous active-low reset
//   issue_valid_i    an instruction is present at decode/issue
//   issue_rs_addr_i  rs source register address
//   issue_rt_addr_i  rt source register address
//   issue_wr_en_i    issuing instruction writes a register
//   issue_wr_addr_i  destination register address
//   issue_memread_i  issuing instruction is a load
//   flush_i          pipeline flush (branch/exception)
//   rs_sel_o         0 = register file, k = forward from stage k-1
//   rt_sel_o         same encoding for rt
//   stall_o          hold issue and insert a bubble
//   stall_cnt_o      saturating count of stalled cycles
// ---------------------------------------------------------------------------
module forwarding_hazard_unit #(
  parameter int ADDR_W      = 3,
  parameter int DEPTH       = 2,
  parameter int LOAD_LAT    = 1,
  parameter int ZERO_REG_EN = 1,
  localparam int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              issue_valid_i,
  input  logic [ADDR_W-1:0] issue_rs_addr_i,
  input  logic [ADDR_W-1:0] issue_rt_addr_i,
  input  logic              issue_wr_en_i,
  input  logic [ADDR_W-1:0] issue_wr_addr_i,
  input  logic              issue_memread_i,
  input  logic              flush_i,
  output logic [SEL_W-1:0]  rs_sel_o,
  output logic [SEL_W-1:0]  rt_sel_o,
  output logic              stall_o,
  output logic [15:0]       stall_cnt_o
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  // Scoreboard: index 0 is the youngest writer (EX/MEM).
  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [DEPTH-1:0]             memread_q, memread_d;
  logic [DEPTH-1:0][ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]                  stall_cnt_q, stall_cnt_d;
  state_t                       state_q, state_d;

  logic [SEL_W-1:0] rs_fwd_s, rt_fwd_s;
  logic             rs_haz_s, rt_haz_s;
  logic             stall_s;

  // Select code of the youngest valid entry writing src; r0 is never
  // forwarded when it is hard-wired to zero.
  function automatic logic [SEL_W-1:0] youngest_sel(
    input logic [DEPTH-1:0]             vld,
    input logic [DEPTH-1:0][ADDR_W-1:0] adr,
    input logic [ADDR_W-1:0]            src
  );
    logic [SEL_W-1:0] sel;
    sel = {SEL_W{1'b0}};
    if (!((ZERO_REG_EN != 0) && (src == {ADDR_W{1'b0}}))) begin
      // Walk oldest to youngest so the youngest match is the one left standing.
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (vld[i] && (adr[i] == src)) begin
          sel = SEL_W'(i + 1);
        end
      end
    end
    return sel;
  endfunction

  // A matched load is unusable while it sits in a stage younger than LOAD_LAT.
  function automatic logic load_hazard(
    input logic [SEL_W-1:0] sel,
    input logic [DEPTH-1:0] mrd
  );
    logic haz;
    haz = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel == SEL_W'(i + 1)) begin
        haz = mrd[i] && (i < LOAD_LAT);
      end
    end
    return haz;
  endfunction

  // Operand match lookup and stall decision.
  always_comb begin
    rs_fwd_s = youngest_sel(valid_q, addr_q, issue_rs_addr_i);
    rt_fwd_s = youngest_sel(valid_q, addr_q, issue_rt_addr_i);
    rs_haz_s = load_hazard(rs_fwd_s, memread_q);
    rt_haz_s = load_hazard(rt_fwd_s, memread_q);
    stall_s  = issue_valid_i & ~flush_i & (rs_haz_s | rt_haz_s);
  end

  // Output selects: zeroed when idle, flushing or stalling.
  always_comb begin
    rs_sel_o = {SEL_W{1'b0}};
    rt_sel_o = {SEL_W{1'b0}};
    if (issue_valid_i && !flush_i && !stall_s) begin
      rs_sel_o = rs_fwd_s;
      rt_sel_o = rt_fwd_s;
    end else begin
      rs_sel_o = {SEL_W{1'b0}};
      rt_sel_o = {SEL_W{1'b0}};
    end
  end

  assign stall_o     = stall_s;
  assign stall_cnt_o = stall_cnt_q;

  // Next-state for the scoreboard shift, stall counter and stall FSM.
  always_comb begin
    valid_d     = valid_q;
    memread_d   = memread_q;
    addr_d      = addr_q;
    stall_cnt_d = stall_cnt_q;
    state_d     = state_q;

    if (flush_i) begin
      valid_d = {DEPTH{1'b0}};
    end else begin
      for (int i = DEPTH - 1; i >= 1; i--) begin
        valid_d[i]   = valid_q[i-1];
        memread_d[i] = memread_q[i-1];
        addr_d[i]    = addr_q[i-1];
      end
      // A stalled instruction enters as a bubble so the hazard drains.
      valid_d[0]   = issue_valid_i & issue_wr_en_i & ~stall_s;
      memread_d[0] = issue_memread_i;
      addr_d[0]    = issue_wr_addr_i;
    end

    if (stall_s && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end

    case (state_q)
      ST_RUN: begin
        if (stall_s) begin
          state_d = ST_STALL;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_STALL: begin
        if (flush_i || !stall_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_STALL;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q     <= {DEPTH{1'b0}};
      memread_q   <= {DEPTH{1'b0}};
      addr_q      <= {(DEPTH * ADDR_W){1'b0}};
      stall_cnt_q <= 16'd0;
      state_q     <= ST_RUN;
    end else begin
      valid_q     <= valid_d;
      memread_q   <= memread_d;
      addr_q      <= addr_d;
      stall_cnt_q <= stall_cnt_d;
      state_q     <= state_d;
    end
  end

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
module tb_forwarding_hazard_unit;

  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic [2:0]  rs_addr;
  logic [2:0]  rt_addr;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic        memread;
  logic        flush;
  logic [1:0]  rs_sel, rt_sel, rs_sel_z, rt_sel_z;
  logic        stall, stall_z;
  logic [15:0] stall_cnt, stall_cnt_z;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        v;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic        we;
    logic [2:0]  wa;
    logic        mr;
    logic        fl;
    logic [1:0]  ers;
    logic [1:0]  ert;
    logic        est;
    logic [1:0]  ers_z;
    logic [15:0] ecnt;
  } vec_t;

  vec_t tbl[24];
  vec_t sb_q[$];

  forwarding_hazard_unit #(.ADDR_W(3), .DEPTH(2), .LOAD_LAT(1), .ZERO_REG_EN(1)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .issue_valid_i(issue_valid),
    .issue_rs_addr_i(rs_addr), .issue_rt_addr_i(rt_addr),
    .issue_wr_en_i(wr_en), .issue_wr_addr_i(wr_addr),
    .issue_memread_i(memread), .flush_i(flush),
    .rs_sel_o(rs_sel), .rt_sel_o(rt_sel), .stall_o(stall), .stall_cnt_o(stall_cnt)
  );

  // Same stimulus, r0 treated as an ordinary register.
  forwarding_hazard_unit #(.ADDR_W(3), .DEPTH(2), .LOAD_LAT(1), .ZERO_REG_EN(0)) u_dut_z (
    .clk_i(clk), .rst_n_i(rst_n), .issue_valid_i(issue_valid),
    .issue_rs_addr_i(rs_addr), .issue_rt_addr_i(rt_addr),
    .issue_wr_en_i(wr_en), .issue_wr_addr_i(wr_addr),
    .issue_memread_i(memread), .flush_i(flush),
    .rs_sel_o(rs_sel_z), .rt_sel_o(rt_sel_z), .stall_o(stall_z), .stall_cnt_o(stall_cnt_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t mk(
    input logic v, input logic [2:0] rs, input logic [2:0] rt, input logic we,
    input logic [2:0] wa, input logic mr, input logic fl,
    input logic [1:0] ers, input logic [1:0] ert, input logic est,
    input logic [1:0] ers_z, input logic [15:0] ecnt
  );
    vec_t r;
    r.v = v; r.rs = rs; r.rt = rt; r.we = we; r.wa = wa; r.mr = mr; r.fl = fl;
    r.ers = ers; r.ert = ert; r.est = est; r.ers_z = ers_z; r.ecnt = ecnt;
    return r;
  endfunction

  task automatic chk(input string name, input int row, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  // One issue cycle: drive after the edge, queue the expectation, compare mid-cycle.
  task automatic step(input vec_t v, input int row);
    vec_t e;
    @(posedge clk);
    #1;
    issue_valid = v.v; rs_addr = v.rs; rt_addr = v.rt;
    wr_en = v.we; wr_addr = v.wa; memread = v.mr; flush = v.fl;
    sb_q.push_back(v);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard row %0d: got empty expected entry", row);
    end else begin
      e = sb_q.pop_front();
      chk("rs_sel", row, 16'(rs_sel), 16'(e.ers));
      chk("rt_sel", row, 16'(rt_sel), 16'(e.ert));
      chk("stall", row, 16'(stall), 16'(e.est));
      chk("rs_sel_z0", row, 16'(rs_sel_z), 16'(e.ers_z));
      chk("stall_cnt", row, stall_cnt, e.ecnt);
    end
  endtask

  initial begin
    //          v  rs rt we wa mr fl  ers ert st rsz cnt
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  // idle after reset
    tbl[1]  = mk(1, 1, 2, 1, 3, 0, 0, 0, 0, 0, 0, 0);  // ALU write r3
    tbl[2]  = mk(1, 3, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);  // back-to-back -> 1
    tbl[3]  = mk(1, 3, 3, 1, 3, 0, 0, 2, 2, 0, 2, 0);  // r3 in stage 1; rewrite r3
    tbl[4]  = mk(0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  // idle: sels forced 0
    tbl[5]  = mk(1, 3, 0, 0, 0, 0, 0, 2, 0, 0, 2, 0);  // one idle between -> 2
    tbl[6]  = mk(1, 0, 0, 1, 6, 0, 0, 0, 0, 0, 0, 0);  // write r6
    tbl[7]  = mk(0, 6, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[9]  = mk(1, 6, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0);  // two idles -> regfile
    tbl[10] = mk(1, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0);  // write r4
    tbl[11] = mk(1, 4, 1, 1, 4, 0, 0, 1, 0, 0, 1, 0);  // write r4 again
    tbl[12] = mk(1, 4, 4, 0, 0, 0, 0, 1, 1, 0, 1, 0);  // youngest wins
    tbl[13] = mk(1, 4, 0, 1, 0, 0, 0, 2, 0, 0, 2, 0);  // write r0
    tbl[14] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);  // r0 only forwards when not zero-reg
    tbl[15] = mk(1, 1, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0);  // load r5
    tbl[16] = mk(1, 2, 5, 1, 7, 0, 0, 0, 0, 1, 0, 0);  // load-use stall
    tbl[17] = mk(1, 2, 5, 1, 7, 0, 0, 0, 2, 0, 0, 1);  // released, forward from stage 1
    tbl[18] = mk(1, 7, 0, 1, 2, 1, 0, 1, 0, 0, 1, 1);  // load r2, forward r7
    tbl[19] = mk(1, 2, 7, 0, 0, 0, 1, 0, 0, 0, 0, 1);  // flush beats stall
    tbl[20] = mk(1, 2, 7, 0, 0, 0, 0, 0, 0, 0, 0, 1);  // entries cleared by flush
    tbl[21] = mk(1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1);  // load r1
    tbl[22] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);  // no issue: no stall
    tbl[23] = mk(1, 1, 0, 0, 0, 0, 0, 2, 0, 0, 2, 1);  // load now in stage 1

    rst_n = 1'b0;
    issue_valid = 1'b0; rs_addr = 3'd0; rt_addr = 3'd0;
    wr_en = 1'b0; wr_addr = 3'd0; memread = 1'b0; flush = 1'b0;
    #2;
    chk("reset_rs_sel", -1, 16'(rs_sel), 16'd0);
    chk("reset_rt_sel", -1, 16'(rt_sel), 16'd0);
    chk("reset_stall", -1, 16'(stall), 16'd0);
    chk("reset_cnt", -1, stall_cnt, 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      step(tbl[i], i);
    end

    // Reset arriving in the middle of a load stall.
    step(mk(1, 0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 1), 100);
    step(mk(1, 0, 5, 0, 0, 0, 0, 0, 0, 1, 0, 1), 101);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_stall", 102, 16'(stall), 16'd0);
    chk("rst_mid_cnt", 102, stall_cnt, 16'd0);
    chk("rst_mid_rt_sel", 102, 16'(rt_sel), 16'd0);
    #2;
    rst_n = 1'b1;
    step(mk(1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0), 103);
    step(mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 104);

    chk("scoreboard_drained", 105, 16'(sb_q.size()), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
